// File: rtl/pixel_mixer.sv
// -----------------------------------------------------------------------------
// pixel_mixer
//   Two-stage pixel compositor for a VGA pipeline. Stage 1 registers every
//   input. Stage 2 selects the highest-priority opaque layer
//   (kid > apple > block > bg), blanks pixels outside the active area and
//   delays sync by the same two cycles. It also tracks kid/apple overlap
//   within a frame and reports it at the frame end with a pulse and a
//   saturating counter.
//
// Ports
//   vga_clk                  pixel clock (only clock)
//   clrn                     asynchronous active-low reset
//   hsync_in, vsync_in       sync from vga_sync
//   col, row                 current pixel coordinate (10 bits each)
//   is_kid/is_apple/is_block layer-coverage flags
//   kid_rgb/apple_rgb/
//   block_rgb/bg_rgb         layer colours {R,G,B}, 4 bits each
//   hsync, vsync             sync delayed to align with r/g/b
//   r, g, b                  final pixel colour
//   apple_hit                one-cycle pulse: overlap seen in previous frame
//   hit_count                saturating count of apple_hit pulses
// -----------------------------------------------------------------------------
module pixel_mixer #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter logic [11:0] KEY_RGB  = 12'hF0F
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  col,
    input  logic [9:0]  row,
    input  logic        is_kid,
    input  logic        is_apple,
    input  logic        is_block,
    input  logic [11:0] kid_rgb,
    input  logic [11:0] apple_rgb,
    input  logic [11:0] block_rgb,
    input  logic [11:0] bg_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        apple_hit,
    output logic [7:0]  hit_count
);

    localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);

    // Stage 1 registers
    logic        r_hs1, r_vs1;
    logic [9:0]  r_col1, r_row1;
    logic        r_kid1, r_apple1, r_block1;
    logic [11:0] r_kid_rgb1, r_apple_rgb1, r_block_rgb1, r_bg_rgb1;

    // Stage 2 registers
    logic        r_hs2, r_vs2;
    logic [11:0] r_rgb2;
    logic        r_hit;
    logic [7:0]  r_count;
    logic        r_overlap;

    // Stage 1 combinational decode
    logic        w_active;
    logic        w_frame_end;
    logic        w_kid_op, w_apple_op, w_block_op;
    logic [11:0] w_pix;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_hs1        <= 1'b1;
            r_vs1        <= 1'b1;
            r_col1       <= '0;
            r_row1       <= '0;
            r_kid1       <= 1'b0;
            r_apple1     <= 1'b0;
            r_block1     <= 1'b0;
            r_kid_rgb1   <= '0;
            r_apple_rgb1 <= '0;
            r_block_rgb1 <= '0;
            r_bg_rgb1    <= '0;
        end else begin
            r_hs1        <= hsync_in;
            r_vs1        <= vsync_in;
            r_col1       <= col;
            r_row1       <= row;
            r_kid1       <= is_kid;
            r_apple1     <= is_apple;
            r_block1     <= is_block;
            r_kid_rgb1   <= kid_rgb;
            r_apple_rgb1 <= apple_rgb;
            r_block_rgb1 <= block_rgb;
            r_bg_rgb1    <= bg_rgb;
        end
    end

    always_comb begin
        w_active    = (r_col1 < LP_H_ACTIVE) && (r_row1 < LP_V_ACTIVE);
        w_frame_end = (r_row1 == LP_V_ACTIVE) && (r_col1 == '0);
        w_kid_op    = r_kid1   && (r_kid_rgb1   != KEY_RGB);
        w_apple_op  = r_apple1 && (r_apple_rgb1 != KEY_RGB);
        w_block_op  = r_block1 && (r_block_rgb1 != KEY_RGB);
        // Background is always opaque, even if it equals the key colour
        w_pix = r_bg_rgb1;
        if (w_kid_op)
            w_pix = r_kid_rgb1;
        else if (w_apple_op)
            w_pix = r_apple_rgb1;
        else if (w_block_op)
            w_pix = r_block_rgb1;
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            r_rgb2    <= '0;
            r_hit     <= 1'b0;
            r_count   <= '0;
            r_overlap <= 1'b0;
        end else begin
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_rgb2 <= w_active ? w_pix : '0;
            r_hit  <= 1'b0;
            // Frame end is never active, so set and clear cannot collide
            if (w_frame_end) begin
                if (r_overlap) begin
                    r_hit     <= 1'b1;
                    r_overlap <= 1'b0;
                    if (r_count != 8'hFF)
                        r_count <= r_count + 8'd1;
                end
            end else if (w_active && w_kid_op && w_apple_op) begin
                r_overlap <= 1'b1;
            end
        end
    end

    assign hsync     = r_hs2;
    assign vsync     = r_vs2;
    assign r         = r_rgb2[11:8];
    assign g         = r_rgb2[7:4];
    assign b         = r_rgb2[3:0];
    assign apple_hit = r_hit;
    assign hit_count = r_count;

endmodule

// File: tb/tb_pixel_mixer.sv
// -----------------------------------------------------------------------------
// tb_pixel_mixer
//   Scoreboard bench: the driver applies one input vector per clock on the
//   falling edge and pushes the expected response from a behavioural model;
//   the monitor pops and compares two rising edges later.
// -----------------------------------------------------------------------------
module tb_pixel_mixer;

    localparam logic [11:0] KEY = 12'hF0F;

    logic        vga_clk = 1'b0;
    logic        clrn;
    logic        hsync_in, vsync_in;
    logic [9:0]  col, row;
    logic        is_kid, is_apple, is_block;
    logic [11:0] kid_rgb, apple_rgb, block_rgb, bg_rgb;
    logic        hsync, vsync;
    logic [3:0]  r, g, b;
    logic        apple_hit;
    logic [7:0]  hit_count;

    pixel_mixer #(.H_ACTIVE(640), .V_ACTIVE(480), .KEY_RGB(KEY)) dut (
        .vga_clk   (vga_clk),
        .clrn      (clrn),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .col       (col),
        .row       (row),
        .is_kid    (is_kid),
        .is_apple  (is_apple),
        .is_block  (is_block),
        .kid_rgb   (kid_rgb),
        .apple_rgb (apple_rgb),
        .block_rgb (block_rgb),
        .bg_rgb    (bg_rgb),
        .hsync     (hsync),
        .vsync     (vsync),
        .r         (r),
        .g         (g),
        .b         (b),
        .apple_hit (apple_hit),
        .hit_count (hit_count)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        hit;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_pulse = 0;

    // Reference state: "has the kid touched an apple this frame" and hit tally
    bit   m_touched;
    int   m_hits;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply one vector and record what the DUT must show two cycles later
    task automatic drive(input logic hs, input logic vs, input int c, input int rw,
                         input logic fk, input logic fa, input logic fb,
                         input logic [11:0] kr, input logic [11:0] ar,
                         input logic [11:0] br, input logic [11:0] bgr);
        exp_t e;
        bit   vis, kid_vis, apple_vis, block_vis;
        @(negedge vga_clk);
        hsync_in = hs; vsync_in = vs;
        col = 10'(c); row = 10'(rw);
        is_kid = fk; is_apple = fa; is_block = fb;
        kid_rgb = kr; apple_rgb = ar; block_rgb = br; bg_rgb = bgr;

        vis       = (c < 640) && (rw < 480);
        kid_vis   = fk && (kr != KEY);
        apple_vis = fa && (ar != KEY);
        block_vis = fb && (br != KEY);
        e.hs  = hs;
        e.vs  = vs;
        e.hit = 1'b0;
        if (!vis)           e.rgb = 12'h000;
        else if (kid_vis)   e.rgb = kr;
        else if (apple_vis) e.rgb = ar;
        else if (block_vis) e.rgb = br;
        else                e.rgb = bgr;
        if (vis && kid_vis && apple_vis) m_touched = 1;
        if (rw == 480 && c == 0 && m_touched) begin
            m_touched = 0;
            e.hit = 1'b1;
            m_hits = (m_hits >= 255) ? 255 : m_hits + 1;
        end
        e.cnt = 8'(m_hits);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b1, 700, 500, 1'b1, 1'b1, 1'b1, 12'h111, 12'h222, 12'h333, 12'h444);
    endtask

    function automatic logic [11:0] rand_rgb();
        return ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    endfunction

    task automatic rand_pixel(input bit allow_overlap);
        logic fk, fa;
        fk = 1'($urandom);
        fa = allow_overlap ? 1'($urandom) : 1'b0;
        drive(1'($urandom), 1'($urandom), $urandom_range(0, 799), $urandom_range(0, 479),
              fk, fa, 1'($urandom), rand_rgb(), rand_rgb(), rand_rgb(), 12'($urandom));
    endtask

    // Compressed frame: a few random pixels, optional kid/apple overlap at
    // (64,91), then the frame-end coordinate (row 480, col 0)
    task automatic frame(input bit overlap, input int n_rand);
        for (int i = 0; i < n_rand; i++) rand_pixel(1'b0);
        if (overlap)
            drive(1'b1, 1'b1, 64, 91, 1'b1, 1'b1, 1'b0, 12'h123, 12'hABC, 12'h000, 12'h456);
        drive(1'b1, 1'b0, 0, 480, 1'b1, 1'b1, 1'b1, 12'h123, 12'hABC, 12'h789, 12'h456);
        idle(2);
    endtask

    // Put inputs at a harmless coordinate so the cycle after release is benign
    task automatic apply_reset();
        @(negedge vga_clk);
        hsync_in = 1'b0; vsync_in = 1'b0;
        col = 10'd700; row = 10'd500;
        is_kid = 1'b1; is_apple = 1'b1; is_block = 1'b1;
        kid_rgb = 12'h123; apple_rgb = 12'hABC; block_rgb = 12'h789; bg_rgb = 12'h456;
        clrn = 1'b0;
        sb.delete();
        m_touched = 0;
        m_hits    = 0;
        #1;
        chk("rst_rgb", {20'd0, r, g, b}, 32'd0);
        chk("rst_sync", {30'd0, hsync, vsync}, 32'd3);
        chk("rst_hit", {31'd0, apple_hit}, 32'd0);
        chk("rst_count", {24'd0, hit_count}, 32'd0);
        @(negedge vga_clk);
        clrn = 1'b1;
    endtask

    // Monitor: output of the vector pushed two falling edges ago
    always @(posedge vga_clk) begin
        #1;
        if (clrn && sb.size() >= 2) begin
            exp_t e, got;
            e   = sb.pop_front();
            got = {hsync, vsync, r, g, b, apple_hit, hit_count};
            if (apple_hit === 1'b1) n_pulse++;
            chk("pixel{hs,vs,rgb,hit,cnt}", 32'(got), 32'(e));
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b1;
        apply_reset();
        idle(2);

        // Pixel (10,10): kid covers apple
        drive(1'b0, 1'b0, 10, 10, 1'b1, 1'b1, 1'b0, 12'h123, 12'hABC, 12'h000, 12'h456);
        // Keyed kid lets apple through
        drive(1'b1, 1'b0, 10, 11, 1'b1, 1'b1, 1'b0, KEY, 12'hABC, 12'h000, 12'h456);
        // Nothing covered: background
        drive(1'b0, 1'b1, 10, 12, 1'b0, 1'b0, 1'b0, 12'h123, 12'hABC, 12'h789, 12'h456);
        // Background shown even when it matches the key
        drive(1'b1, 1'b1, 11, 12, 1'b1, 1'b1, 1'b1, KEY, KEY, KEY, KEY);
        // Off-screen column with all layers opaque, sync toggling
        drive(1'b0, 1'b1, 700, 20, 1'b1, 1'b1, 1'b1, 12'h123, 12'hABC, 12'h789, 12'h456);
        drive(1'b1, 1'b0, 700, 21, 1'b1, 1'b1, 1'b1, 12'h123, 12'hABC, 12'h789, 12'h456);
        drive(1'b0, 1'b1, 639, 479, 1'b0, 1'b0, 1'b1, 12'h123, 12'hABC, 12'h789, 12'h456);
        drive(1'b1, 1'b0, 640, 479, 1'b0, 1'b0, 1'b1, 12'h123, 12'hABC, 12'h789, 12'h456);
        drive(1'b0, 1'b0, 639, 480, 1'b0, 1'b0, 1'b1, 12'h123, 12'hABC, 12'h789, 12'h456);
        idle(2);

        // Random pixels, overlap allowed; frame end never reached here
        for (int i = 0; i < 200; i++) rand_pixel(1'b1);
        idle(1);
        // Flush any accidental random overlap so the frame checks start clean
        frame(1'b0, 0);

        // One frame with overlap, then one without
        n_pulse = 0;
        apply_reset();
        idle(1);
        frame(1'b1, 10);
        idle(1);
        chk("count_after_hit_frame", {24'd0, hit_count}, 32'd1);
        chk("pulses_after_hit_frame", 32'(n_pulse), 32'd1);
        frame(1'b0, 10);
        idle(1);
        chk("count_after_clean_frame", {24'd0, hit_count}, 32'd1);
        chk("pulses_after_clean_frame", 32'(n_pulse), 32'd1);

        // 300 overlapping frames: counter saturates, pulses continue
        for (int f = 0; f < 300; f++) frame(1'b1, $urandom_range(0, 4));
        idle(1);
        chk("count_saturated", {24'd0, hit_count}, 32'd255);
        chk("pulses_300_frames", 32'(n_pulse), 32'd301);

        // Overlap mid-frame, then reset: no hit may survive
        drive(1'b1, 1'b1, 64, 91, 1'b1, 1'b1, 1'b0, 12'h123, 12'hABC, 12'h000, 12'h456);
        idle(1);
        apply_reset();
        n_pulse = 0;
        frame(1'b0, 5);
        idle(1);
        chk("count_after_reset_frame", {24'd0, hit_count}, 32'd0);
        chk("pulses_after_reset_frame", 32'(n_pulse), 32'd0);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_mixer.md
PIXEL_MIXER -- requirements
Module: pixel_mixer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter KEY_RGB, default 12'hF0F, transparent colour key.
REQ-004 SHALL have port vga_clk  input  1  pixel clock; only clock in the block.
REQ-005 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports hsync_in, vsync_in  input  1 each  sync from vga_sync.
REQ-007 SHALL have ports col, row  input  10 each  current pixel coordinate from vga_sync.
REQ-008 SHALL have ports is_kid, is_apple, is_block  input  1 each  layer-coverage flags.
REQ-009 SHALL have ports kid_rgb, apple_rgb, block_rgb, bg_rgb  input  12 each  layer colours, {R,G,B} 4 bits each.
REQ-010 SHALL have ports hsync, vsync  output  1 each  sync delayed to match pixel data.
REQ-011 SHALL have ports r, g, b  output  4 each  final pixel colour.
REQ-012 SHALL have port apple_hit  output  1  one-cycle pulse when kid touched an apple in the previous frame.
REQ-013 SHALL have port hit_count  output  8  saturating count of apple_hit pulses.

Function
REQ-014 SHALL register all inputs in stage 1 on vga_clk rising edge; SHALL compute mix and register outputs in stage 2.
REQ-015 SHALL have hsync, vsync, r, g, b latency of exactly 2 vga_clk cycles from the inputs.
REQ-016 SHALL treat a layer as opaque iff its flag = 1 and its rgb != KEY_RGB.
REQ-017 SHALL use priority kid > apple > block > bg; bg_rgb SHALL be used regardless of KEY_RGB.
REQ-018 SHALL define active as col < H_ACTIVE and row < V_ACTIVE (stage-1 values).
REQ-019 SHALL output r = g = b = 0 when not active, regardless of flags.
REQ-020 SHALL set an internal overlap latch on any active stage-1 cycle where kid and apple are both opaque.
REQ-021 SHALL detect frame end as the stage-1 cycle with row == V_ACTIVE and col == 0.
REQ-022 SHALL, at frame end with latch set: apple_hit = 1 for exactly that following cycle, latch cleared, hit_count += 1.
REQ-023 SHALL, at frame end with latch clear: apple_hit stays 0, hit_count unchanged.
REQ-024 SHALL saturate hit_count at 8'hFF; further hits still pulse apple_hit.
REQ-025 SHALL give apple_hit pulses a latency of 2 cycles from the frame-end input cycle.
REQ-026 SHALL never set the latch on the frame-end cycle itself, since it is not active.
REQ-027 SHALL not carry a hit across a reset: the latch is cleared by reset, and a partial frame after reset counts only post-reset overlaps.

Reset
REQ-028 SHALL, while clrn = 0, asynchronously force r, g, b, apple_hit = 0, hit_count = 0, overlap latch = 0, all pipeline data registers = 0, and hsync and vsync pipeline registers = 1.
REQ-029 SHALL resume normal operation on the first vga_clk rising edge after clrn returns to 1, with outputs valid after 2 edges.

Verification
REQ-030 SHALL check: pixel (10,10) with is_kid = 1, kid_rgb = 12'h123, is_apple = 1, apple_rgb = 12'hABC -> r, g, b = 1, 2, 3 two cycles later.
REQ-031 SHALL check: kid_rgb = 12'hF0F with is_kid = 1, apple opaque 12'hABC -> output A, B, C; with all flags 0 and bg_rgb = 12'h456 -> output 4, 5, 6.
REQ-032 SHALL check: col = 700 and all layers opaque -> r, g, b = 0; hsync_in/vsync_in toggles appear on hsync/vsync exactly 2 cycles later.
REQ-033 SHALL check: a full vga_sync frame with kid and apple overlapping at (64,91) -> one apple_hit pulse 2 cycles after (row 480, col 0) and hit_count = 1; next frame without overlap -> no pulse, hit_count = 1.
REQ-034 SHALL check: force 300 overlapping frames -> hit_count = 255 with apple_hit still pulsing each frame.
REQ-035 SHALL check: overlap mid-frame then clrn pulsed low -> all outputs reset immediately, no apple_hit at that frame end, hit_count = 0.
